parity_frame_tx: RTL and testbench
==================================

Name: parity_frame_tx

Overview:
Serial framing stage that sits directly downstream of the even/odd parity generator. It accepts a DATA_W-bit word plus a parity-mode select through a valid/ready handshake, and computes the parity bit internally using the same rules as the generator. It then shifts out a start bit, the data bits (LSB first), the parity bit and the stop bit(s) on a single serial line. Each bit is held for a programmable number of clocks.

Parameters:
DATA_W, 3, data bits per frame (matches the 3-bit a/b/c word)
BIT_CYCLES, 4, clock cycles each serial bit is held (>=1)
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  word/mode available
in_ready  output  1  block can accept a word (high only in IDLE)
in_data  input  DATA_W  word to send; in_data[0] is transmitted first
in_odd  input  1  parity mode: 0 = even parity, 1 = odd parity (same meaning as x)
tx_serial  output  1  serial line; idle level 1
tx_busy  output  1  frame in progress
parity_out  output  1  parity bit of the most recently accepted word
frame_done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Clocking and reset: one clock domain (clk). rst is synchronous and active-high; all state updates on the rising edge of clk.
- Reset values: state=IDLE, tx_serial=1, tx_busy=0, frame_done=0, parity_out=0, bit and cycle counters=0. in_ready=1 in the first cycle after reset.
- Handshake: a transfer occurs on an edge where in_valid && in_ready. in_ready = (state==IDLE) and depends only on state, not on in_valid.
  - in_valid and in_data while busy are ignored; nothing is queued.
- Capture: on a transfer, register in_data and in_odd.
  - parity_out <= ^in_data ^ in_odd, so even mode makes the total ones count even and odd mode makes it odd.
- States: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - IDLE: tx_serial=1.
  - START: tx_serial=0.
  - DATA: tx_serial = data[bit_idx], with bit_idx running 0..DATA_W-1.
  - PARITY: tx_serial = parity.
  - STOP: tx_serial=1 for STOP_BITS bit periods.
- Bit timing: every state except IDLE lasts exactly BIT_CYCLES clocks per bit.
  - The cycle counter runs 0..BIT_CYCLES-1 and clears on each state or bit change.
- Latency: tx_serial, tx_busy and state are registered.
  - On the accept edge, state goes to START, tx_serial goes to 0 and tx_busy goes to 1.
  - Frame length is (2+DATA_W+STOP_BITS)*BIT_CYCLES cycles; 24 cycles with defaults.
- Completion: on the edge that leaves the last STOP cycle, state goes to IDLE, tx_busy goes to 0, and frame_done is 1 for exactly one cycle.
  - in_ready is 1 in that same cycle, so back-to-back frames have zero idle bit periods.
- Simultaneous events: rst overrides everything, including a transfer on the same edge.
- Reset mid-frame: the frame is aborted with no frame_done pulse, and tx_serial returns to 1 on the next cycle.
- parity_out holds its value until the next transfer or rst.

Decomposition:
- Shared package holds:
  - the state encoding localparams (IDLE, START, DATA, PARITY, STOP);
  - a parity function parity_calc(data, odd_mode) returning ^data ^ odd_mode. The parity generator and a future receiver/checker use this same function.
- One natural sub-module: bit_timer.
  - Parameterised by BIT_CYCLES.
  - Inputs clk, rst, clear. Output tick is high on the last cycle of a bit period.
  - The FSM advances only on tick.

Test Plan:
1. Even mode, in_data=3'b011, in_odd=0, defaults -> parity_out=0; tx_serial sequence 0,1,1,0,0,1, each bit held 4 clocks; frame_done pulses exactly 24 cycles after the accept edge.
2. Odd mode, in_data=3'b011, in_odd=1 -> parity_out=1; sequence 0,1,1,0,1,1. Also in_data=3'b111 gives parity 1 in even mode and 0 in odd mode.
3. All 8 data values in both modes -> in every frame, the count of ones across data plus parity is even when in_odd=0 and odd when in_odd=1.
4. in_valid held high continuously with two words (3'b001 then 3'b110) -> second accept occurs in the frame_done cycle; no idle-high gap between stop bit and next start bit; in_data changes mid-frame do not alter the bits being sent.
5. rst asserted during the DATA state (cycle 10) -> next cycle tx_serial=1, tx_busy=0, in_ready=1, no frame_done; a new frame then sends correctly.
6. BIT_CYCLES=1, STOP_BITS=2 -> frame is 7 cycles long, with two consecutive high stop cycles before frame_done.

Source files
------------

// File: rtl/parity_frame_tx_pkg.sv
// Shared definitions for the parity framing path: FSM state encoding and the
// parity rule common to the generator, this transmitter and a future checker.
package parity_frame_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Even mode (odd_mode=0) makes data+parity carry an even number of ones.
  // Words wider than 32 bits must be reduced by the caller first.
  function automatic logic parity_calc(input logic [31:0] data, input logic odd_mode);
    return (^data) ^ odd_mode;
  endfunction

endpackage

// File: rtl/parity_frame_tx_bit_timer.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 and raises tick on the last cycle
// of each bit period; clear holds the count at zero.
module parity_frame_tx_bit_timer
  import parity_frame_tx_pkg::*;
#(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB first, parity bit,
// STOP_BITS stop bits, each held BIT_CYCLES clocks; valid/ready word intake.
module parity_frame_tx
  import parity_frame_tx_pkg::*;
#(
  parameter int DATA_W     = 3,
  parameter int BIT_CYCLES = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_odd,
  output logic              tx_serial,
  output logic              tx_busy,
  output logic              parity_out,
  output logic              frame_done
);

  localparam int IDX_MAX = (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
  localparam int IDX_W   = $clog2(IDX_MAX + 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  state_t            state;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_next;
  logic [IDX_W-1:0]  bit_idx;
  logic              tick;
  logic              timer_clear;
  logic              accept;

  assign in_ready    = (state == ST_IDLE);
  assign accept      = in_valid && in_ready;
  assign timer_clear = (state == ST_IDLE);
  assign data_next   = data_q >> 1;

  parity_frame_tx_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(timer_clear),
    .tick (tick)
  );

  // Data word is consumed by shifting right, so bit 0 is always the next one out.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_q <= in_data;
    end else if (state == ST_DATA && tick) begin
      data_q <= data_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      tx_serial  <= 1'b1;
      tx_busy    <= 1'b0;
      frame_done <= 1'b0;
      parity_out <= 1'b0;
      bit_idx    <= '0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          tx_serial <= 1'b1;
          if (in_valid) begin
            parity_out <= parity_calc(32'(in_data), in_odd);
            state      <= ST_START;
            tx_serial  <= 1'b0;
            tx_busy    <= 1'b1;
            bit_idx    <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            state     <= ST_DATA;
            tx_serial <= data_q[0];
            bit_idx   <= '0;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx == LAST_DATA) begin
              state     <= ST_PARITY;
              tx_serial <= parity_out;
            end else begin
              bit_idx   <= bit_idx + IDX_W'(1);
              tx_serial <= data_next[0];
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state     <= ST_STOP;
            tx_serial <= 1'b1;
            bit_idx   <= '0;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (bit_idx == LAST_STOP) begin
              state      <= ST_IDLE;
              tx_busy    <= 1'b0;
              frame_done <= 1'b1;
              bit_idx    <= '0;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          tx_serial <= 1'b1;
          tx_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Self-checking bench for parity_frame_tx: default instance plus a
// BIT_CYCLES=1 / STOP_BITS=2 instance, compared against a frame-level model.
module tb_parity_frame_tx;

  localparam int DW = 3;
  localparam int A_LEN = (2 + DW + 1) * 4;
  localparam int B_LEN = (2 + DW + 2) * 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          a_in_valid, a_in_ready, a_in_odd, a_tx_serial, a_tx_busy, a_parity_out, a_frame_done;
  logic [DW-1:0] a_in_data;
  logic          b_in_valid, b_in_ready, b_in_odd, b_tx_serial, b_tx_busy, b_parity_out, b_frame_done;
  logic [DW-1:0] b_in_data;

  int nvec = 0;
  int nerr = 0;

  parity_frame_tx #(.DATA_W(DW), .BIT_CYCLES(4), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_odd(a_in_odd), .tx_serial(a_tx_serial),
    .tx_busy(a_tx_busy), .parity_out(a_parity_out), .frame_done(a_frame_done)
  );

  parity_frame_tx #(.DATA_W(DW), .BIT_CYCLES(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_odd(b_in_odd), .tx_serial(b_tx_serial),
    .tx_busy(b_tx_busy), .parity_out(b_parity_out), .frame_done(b_frame_done)
  );

  // Parity bit that brings the total ones count to even (odd=0) or odd (odd=1).
  function automatic logic ref_parity(input logic [DW-1:0] d, input logic odd);
    return ((($countones(d) + (odd ? 1 : 0)) % 2) == 1);
  endfunction

  // Line level k cycles after the accept edge for a frame of the given shape.
  function automatic logic ref_bit(input logic [DW-1:0] d, input logic odd,
                                   input int bc, input int k);
    int idx;
    idx = k / bc;
    if (idx == 0) return 1'b0;
    if (idx <= DW) return d[idx-1];
    if (idx == DW + 1) return ref_parity(d, odd);
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for A to be ready, then presents one word for one edge.
  task automatic start_a(input logic [DW-1:0] d, input logic odd);
    int n = 0;
    while (!a_in_ready && n < 100) begin
      step();
      n++;
    end
    nvec++;
    if (a_in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL a_ready_timeout: in_ready=%0b required 1", a_in_ready);
    end
    a_in_valid = 1'b1;
    a_in_data  = d;
    a_in_odd   = odd;
    step();
    a_in_valid = 1'b0;
    a_in_data  = DW'($urandom);
    a_in_odd   = 1'($urandom);
  endtask

  // Called at the sample point right after the accept edge; returns at the
  // sample point of the frame_done cycle.
  task automatic check_frame_a(input logic [DW-1:0] d, input logic odd);
    logic err_seen;
    nvec++;
    if (a_parity_out !== ref_parity(d, odd)) begin
      nerr++;
      $display("FAIL a_parity d=%b odd=%0b: got %0b required %0b", d, odd, a_parity_out, ref_parity(d, odd));
    end
    err_seen = 1'b0;
    for (int k = 0; k < A_LEN; k++) begin
      nvec++;
      if (a_tx_serial !== ref_bit(d, odd, 4, k) || a_tx_busy !== 1'b1 ||
          a_frame_done !== 1'b0 || a_in_ready !== 1'b0) begin
        nerr++;
        if (!err_seen)
          $display("FAIL a_frame d=%b odd=%0b cyc=%0d: tx=%0b busy=%0b done=%0b ready=%0b required tx=%0b busy=1 done=0 ready=0",
                   d, odd, k, a_tx_serial, a_tx_busy, a_frame_done, a_in_ready, ref_bit(d, odd, 4, k));
        err_seen = 1'b1;
      end
      step();
    end
    nvec++;
    if (a_frame_done !== 1'b1 || a_tx_busy !== 1'b0 || a_tx_serial !== 1'b1 || a_in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL a_done d=%b: done=%0b busy=%0b tx=%0b ready=%0b required done=1 busy=0 tx=1 ready=1",
               d, a_frame_done, a_tx_busy, a_tx_serial, a_in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    nvec++;
    if (a_tx_serial !== 1'b1 || a_tx_busy !== 1'b0 || a_frame_done !== 1'b0 ||
        a_parity_out !== 1'b0 || a_in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL a_reset: tx=%0b busy=%0b done=%0b par=%0b ready=%0b required 1 0 0 0 1",
               a_tx_serial, a_tx_busy, a_frame_done, a_parity_out, a_in_ready);
    end
    nvec++;
    if (b_tx_serial !== 1'b1 || b_tx_busy !== 1'b0 || b_frame_done !== 1'b0 ||
        b_parity_out !== 1'b0 || b_in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL b_reset: tx=%0b busy=%0b done=%0b par=%0b ready=%0b required 1 0 0 0 1",
               b_tx_serial, b_tx_busy, b_frame_done, b_parity_out, b_in_ready);
    end
  endtask

  task automatic test_even_odd();
    start_a(3'b011, 1'b0);
    check_frame_a(3'b011, 1'b0);
    start_a(3'b011, 1'b1);
    check_frame_a(3'b011, 1'b1);
    start_a(3'b111, 1'b0);
    check_frame_a(3'b111, 1'b0);
    start_a(3'b111, 1'b1);
    check_frame_a(3'b111, 1'b1);
  endtask

  task automatic test_all_values();
    for (int v = 0; v < 8; v++) begin
      for (int m = 0; m < 2; m++) begin
        start_a(DW'(v), 1'(m));
        check_frame_a(DW'(v), 1'(m));
        nvec++;
        if ((($countones(DW'(v)) + (a_parity_out ? 1 : 0)) % 2) != m) begin
          nerr++;
          $display("FAIL a_ones_count d=%0d odd=%0d: parity=%0b gives wrong total ones parity", v, m, a_parity_out);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    logic          o;
    for (int i = 0; i < 12; i++) begin
      d = DW'($urandom);
      o = 1'($urandom);
      start_a(d, o);
      check_frame_a(d, o);
    end
  endtask

  task automatic test_back_to_back();
    a_in_valid = 1'b1;
    a_in_data  = 3'b001;
    a_in_odd   = 1'b0;
    step();
    a_in_data = 3'b110;
    check_frame_a(3'b001, 1'b0);
    step();
    a_in_valid = 1'b0;
    a_in_data  = 3'b000;
    check_frame_a(3'b110, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    logic seen_done;
    start_a(3'b101, 1'b1);
    for (int k = 0; k < 10; k++) step();
    nvec++;
    if (a_tx_serial !== ref_bit(3'b101, 1'b1, 4, 10) || a_tx_busy !== 1'b1) begin
      nerr++;
      $display("FAIL a_pre_abort: tx=%0b busy=%0b required tx=%0b busy=1",
               a_tx_serial, a_tx_busy, ref_bit(3'b101, 1'b1, 4, 10));
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    nvec++;
    if (a_tx_serial !== 1'b1 || a_tx_busy !== 1'b0 || a_in_ready !== 1'b1 ||
        a_frame_done !== 1'b0 || a_parity_out !== 1'b0) begin
      nerr++;
      $display("FAIL a_abort: tx=%0b busy=%0b ready=%0b done=%0b par=%0b required 1 0 1 0 0",
               a_tx_serial, a_tx_busy, a_in_ready, a_frame_done, a_parity_out);
    end
    seen_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (a_frame_done !== 1'b0 || a_tx_serial !== 1'b1) seen_done = 1'b1;
    end
    nvec++;
    if (seen_done) begin
      nerr++;
      $display("FAIL a_abort_quiet: done/tx activity=%0b required 0", seen_done);
    end
    start_a(3'b010, 1'b0);
    check_frame_a(3'b010, 1'b0);
  endtask

  task automatic test_short_frame();
    logic [DW-1:0] d;
    logic          o;
    logic          err_seen;
    int            n;
    for (int i = 0; i < 6; i++) begin
      d = (i == 0) ? 3'b011 : DW'($urandom);
      o = (i == 0) ? 1'b0 : 1'($urandom);
      n = 0;
      while (!b_in_ready && n < 100) begin
        step();
        n++;
      end
      nvec++;
      if (b_in_ready !== 1'b1) begin
        nerr++;
        $display("FAIL b_ready_timeout: in_ready=%0b required 1", b_in_ready);
      end
      b_in_valid = 1'b1;
      b_in_data  = d;
      b_in_odd   = o;
      step();
      b_in_valid = 1'b0;
      b_in_data  = DW'($urandom);
      err_seen   = 1'b0;
      for (int k = 0; k < B_LEN; k++) begin
        nvec++;
        if (b_tx_serial !== ref_bit(d, o, 1, k) || b_tx_busy !== 1'b1 || b_frame_done !== 1'b0) begin
          nerr++;
          if (!err_seen)
            $display("FAIL b_frame d=%b odd=%0b cyc=%0d: tx=%0b busy=%0b done=%0b required tx=%0b busy=1 done=0",
                     d, o, k, b_tx_serial, b_tx_busy, b_frame_done, ref_bit(d, o, 1, k));
          err_seen = 1'b1;
        end
        step();
      end
      nvec++;
      if (b_frame_done !== 1'b1 || b_tx_busy !== 1'b0 || b_parity_out !== ref_parity(d, o)) begin
        nerr++;
        $display("FAIL b_done d=%b odd=%0b: done=%0b busy=%0b par=%0b required done=1 busy=0 par=%0b",
                 d, o, b_frame_done, b_tx_busy, b_parity_out, ref_parity(d, o));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    a_in_valid = 1'b0;
    a_in_data  = '0;
    a_in_odd   = 1'b0;
    b_in_valid = 1'b0;
    b_in_data  = '0;
    b_in_odd   = 1'b0;
    #1;
    test_reset();
    test_even_odd();
    test_all_values();
    test_random();
    test_back_to_back();
    test_reset_mid_frame();
    test_short_frame();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
